// File: rtl/operand_input_reg.sv
`default_nettype none
// ============================================================================
// Module   : operand_input_reg
// Brief    : Deserialises two LSB-first serial operands (A then B) and holds the
//            completed pair until the consumer acknowledges it.
// Revision : 1.0
// ============================================================================
module operand_input_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             serial_in,
    input  logic             bit_valid_in,
    input  logic             ack_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] op_a_out,
    output logic [WIDTH-1:0] op_b_out,
    output logic             operands_rdy,
    output logic             overrun_err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        RECV_A = 2'd0,
        RECV_B = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shreg;

    logic [WIDTH-1:0] w_word;
    logic             w_last;

    // The word as it will look once the current bit has been shifted in.
    assign w_word = {serial_in, r_shreg[WIDTH-1:1]};
    assign w_last = (r_cnt == c_LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= RECV_A;
            r_cnt        <= '0;
            r_shreg      <= '0;
            op_a_out     <= '0;
            op_b_out     <= '0;
            operands_rdy <= 1'b0;
            overrun_err  <= 1'b0;
            ready_out    <= 1'b1;
        end else begin
            case (r_state)
                RECV_A, RECV_B: begin
                    if (bit_valid_in) begin
                        r_shreg <= w_word;
                        if (w_last) begin
                            r_cnt <= '0;
                            if (r_state == RECV_A) begin
                                op_a_out <= w_word;
                                r_state  <= RECV_B;
                            end else begin
                                op_b_out     <= w_word;
                                operands_rdy <= 1'b1;
                                ready_out    <= 1'b0;
                                r_state      <= FULL;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                FULL: begin
                    // Bits arriving while the pair is held are lost; flag it.
                    if (bit_valid_in) begin
                        overrun_err <= 1'b1;
                    end
                    if (ack_in) begin
                        operands_rdy <= 1'b0;
                        ready_out    <= 1'b1;
                        r_state      <= RECV_A;
                    end
                end
                default: begin
                    r_state   <= RECV_A;
                    r_cnt     <= '0;
                    ready_out <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_operand_input_reg.sv
`default_nettype none
// Directed bench for operand_input_reg: expected operand pairs are queued when
// their bits are driven and popped when operands_rdy reports a completed pair.
module tb_operand_input_reg;

    localparam int WIDTH = 16;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             serial_in;
    logic             bit_valid_in;
    logic             ack_in;
    logic             ready_out;
    logic [WIDTH-1:0] op_a_out;
    logic [WIDTH-1:0] op_b_out;
    logic             operands_rdy;
    logic             overrun_err;

    int checks   = 0;
    int failures = 0;
    logic [2*WIDTH-1:0] sb_q[$];

    operand_input_reg #(.WIDTH(WIDTH)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .serial_in    (serial_in),
        .bit_valid_in (bit_valid_in),
        .ack_in       (ack_in),
        .ready_out    (ready_out),
        .op_a_out     (op_a_out),
        .op_b_out     (op_b_out),
        .operands_rdy (operands_rdy),
        .overrun_err  (overrun_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read there too.
    task automatic send_bits(input logic [WIDTH-1:0] w, input int lo, input int hi, input int gap);
        logic [WIDTH-1:0] v;
        v = w;
        for (int i = lo; i <= hi; i++) begin
            serial_in    = v[i];
            bit_valid_in = 1'b1;
            @(negedge clk_in);
            bit_valid_in = 1'b0;
            repeat (gap) @(negedge clk_in);
        end
    endtask

    task automatic push_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        sb_q.push_back({a, b});
    endtask

    task automatic send_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int gap);
        push_pair(a, b);
        send_bits(a, 0, WIDTH-1, gap);
        send_bits(b, 0, WIDTH-1, gap);
    endtask

    task automatic check_pair(input string tag);
        logic [2*WIDTH-1:0] exp;
        int n;
        n = 0;
        while (!operands_rdy && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        check({tag, "_rdy"}, {{(WIDTH-1){1'b0}}, operands_rdy}, 1);
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_queue observed=empty expected=pair", tag);
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_a"}, op_a_out, exp[2*WIDTH-1:WIDTH]);
            check({tag, "_b"}, op_b_out, exp[WIDTH-1:0]);
        end
    endtask

    task automatic do_reset();
        rst_in       = 1'b1;
        bit_valid_in = 1'b1;
        ack_in       = 1'b1;
        serial_in    = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in       = 1'b0;
        bit_valid_in = 1'b0;
        ack_in       = 1'b0;
        sb_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},   {{(WIDTH-1){1'b0}}, ready_out},    1);
        check({tag, "_rdy"},     {{(WIDTH-1){1'b0}}, operands_rdy}, 0);
        check({tag, "_a"},       op_a_out, 0);
        check({tag, "_b"},       op_b_out, 0);
        check({tag, "_overrun"}, {{(WIDTH-1){1'b0}}, overrun_err},  0);
    endtask

    task automatic pulse_ack();
        ack_in = 1'b1;
        @(negedge clk_in);
        ack_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b0; serial_in = 1'b0; bit_valid_in = 1'b0; ack_in = 1'b0;
        @(negedge clk_in);
        do_reset();
        check_reset_vals("reset0");

        // Continuous stream: exact latency of operands_rdy
        push_pair(16'h3C00, 16'h4000);
        send_bits(16'h3C00, 0, WIDTH-1, 0);
        check("cont_a_done", op_a_out, 16'h3C00);
        send_bits(16'h4000, 0, WIDTH-2, 0);
        check("cont_rdy_early", {{(WIDTH-1){1'b0}}, operands_rdy}, 0);
        check("cont_ready_early", {{(WIDTH-1){1'b0}}, ready_out}, 1);
        send_bits(16'h4000, WIDTH-1, WIDTH-1, 0);
        check("cont_rdy", {{(WIDTH-1){1'b0}}, operands_rdy}, 1);
        check("cont_ready", {{(WIDTH-1){1'b0}}, ready_out}, 0);
        check_pair("cont");
        pulse_ack();
        check("ack_rdy", {{(WIDTH-1){1'b0}}, operands_rdy}, 0);
        check("ack_ready", {{(WIDTH-1){1'b0}}, ready_out}, 1);

        // Valid every third cycle
        push_pair(16'h3C00, 16'h4000);
        send_bits(16'h3C00, 0, WIDTH-1, 2);
        send_bits(16'h4000, 0, WIDTH-2, 2);
        check("gap_rdy_early", {{(WIDTH-1){1'b0}}, operands_rdy}, 0);
        send_bits(16'h4000, WIDTH-1, WIDTH-1, 0);
        check("gap_rdy", {{(WIDTH-1){1'b0}}, operands_rdy}, 1);
        check_pair("gap");

        // Overrun in FULL, then a new pair after ack
        serial_in = 1'b1; bit_valid_in = 1'b1;
        repeat (3) @(negedge clk_in);
        bit_valid_in = 1'b0;
        check("ovr_flag", {{(WIDTH-1){1'b0}}, overrun_err}, 1);
        check("ovr_rdy", {{(WIDTH-1){1'b0}}, operands_rdy}, 1);
        check("ovr_a_hold", op_a_out, 16'h3C00);
        check("ovr_b_hold", op_b_out, 16'h4000);
        pulse_ack();
        check("ovr_ack_ready", {{(WIDTH-1){1'b0}}, ready_out}, 1);
        push_pair(16'hC500, 16'h0001);
        send_bits(16'hC500, 0, WIDTH-1, 0);
        check("ovr_new_a", op_a_out, 16'hC500);
        check("ovr_old_b", op_b_out, 16'h4000);
        check("ovr_mid_rdy", {{(WIDTH-1){1'b0}}, operands_rdy}, 0);
        send_bits(16'h0001, 0, WIDTH-1, 0);
        check_pair("ovr_new");
        check("ovr_sticky", {{(WIDTH-1){1'b0}}, overrun_err}, 1);
        pulse_ack();

        // Ack and valid in the same FULL cycle
        do_reset();
        send_pair(16'h1234, 16'hABCD, 0);
        check_pair("same_pre");
        ack_in = 1'b1; bit_valid_in = 1'b1; serial_in = 1'b1;
        @(negedge clk_in);
        ack_in = 1'b0; bit_valid_in = 1'b0;
        check("same_rdy", {{(WIDTH-1){1'b0}}, operands_rdy}, 0);
        check("same_ready", {{(WIDTH-1){1'b0}}, ready_out}, 1);
        check("same_overrun", {{(WIDTH-1){1'b0}}, overrun_err}, 1);
        send_pair(16'h8001, 16'h00FF, 0);
        check_pair("same_next");
        pulse_ack();

        // Reset mid-stream discards partial bits
        do_reset();
        send_bits(16'hFFFF, 0, WIDTH-1, 0);
        send_bits(16'hFFFF, 0, 3, 0);
        do_reset();
        check_reset_vals("reset_mid");
        send_pair(16'h7BFF, 16'hFBFF, 0);
        check_pair("post_reset");
        pulse_ack();

        // Ack ignored while receiving
        push_pair(16'h5A5A, 16'hA5A5);
        send_bits(16'h5A5A, 0, 6, 0);
        pulse_ack();
        check("ign_a_ready", {{(WIDTH-1){1'b0}}, ready_out}, 1);
        check("ign_a_rdy", {{(WIDTH-1){1'b0}}, operands_rdy}, 0);
        check("ign_a_hold", op_a_out, 16'h7BFF);
        send_bits(16'h5A5A, 7, WIDTH-1, 0);
        check("ign_a_done", op_a_out, 16'h5A5A);
        send_bits(16'hA5A5, 0, 9, 1);
        pulse_ack();
        check("ign_b_ready", {{(WIDTH-1){1'b0}}, ready_out}, 1);
        check("ign_b_rdy", {{(WIDTH-1){1'b0}}, operands_rdy}, 0);
        check("ign_b_hold", op_b_out, 16'hFBFF);
        send_bits(16'hA5A5, 10, WIDTH-1, 0);
        check_pair("ign");
        pulse_ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
